frame_strobe_sequencer: RTL and testbench
=========================================

FRAME_STROBE_SEQUENCER -- requirements
Module: frame_strobe_sequencer

Interface
REQ-001: The block SHALL have parameter MaxFramesPerCol, default 20, giving the number of frame strobe lines per column.
REQ-002: The block SHALL have parameter FrameBitsPerRow, default 32, giving the frame data word width.
REQ-003: The block SHALL have parameter StrobeWidth, default 2, range 1-15, giving strobe assertion length in cycles.
REQ-004: UserCLK  input  1  the single clock; all state changes on its rising edge.
REQ-005: reset  input  1  asynchronous, active-high reset.
REQ-006: cmd_valid  input  1  frame write request.
REQ-007: cmd_ready  output  1  sequencer can accept a request.
REQ-008: cmd_addr  input  5  target frame index.
REQ-009: cmd_data  input  FrameBitsPerRow  frame payload.
REQ-010: FrameData  output  FrameBitsPerRow  registered frame data driven toward the column tiles.
REQ-011: FrameStrobe  output  MaxFramesPerCol  one-hot strobe to the column; this feeds tile FrameStrobe inputs.
REQ-012: done  output  1  single-cycle pulse when a frame write completes.
REQ-013: addr_err  output  1  sticky flag for an out-of-range address.
REQ-014: frame_count  output  16  count of completed frame writes.

Function
REQ-015: The block SHALL implement the states IDLE, SETUP, STROBE and HOLD.
REQ-016: cmd_ready SHALL be 1 only in IDLE; a handshake is cmd_valid=1 and cmd_ready=1 at a rising edge.
REQ-017: On a handshake with cmd_addr < MaxFramesPerCol, the block SHALL latch cmd_addr and cmd_data, drive FrameData=cmd_data from the next cycle, and go to SETUP.
REQ-018: On a handshake with cmd_addr >= MaxFramesPerCol, the block SHALL set addr_err, drop the command, remain in IDLE, and leave FrameData, FrameStrobe and frame_count unchanged.
REQ-019: SETUP SHALL last exactly 1 cycle with FrameStrobe all-zero, then go to STROBE.
REQ-020: STROBE SHALL last exactly StrobeWidth cycles with FrameStrobe[addr]=1 and all other bits 0; an internal counter SHALL time it.
REQ-021: HOLD SHALL last exactly 1 cycle with FrameStrobe all-zero, FrameData held, and done=1, then go to IDLE.
REQ-022: frame_count SHALL increment in the HOLD cycle and wrap from 0xFFFF to 0x0000.
REQ-023: FrameData SHALL remain stable from SETUP through HOLD, and SHALL hold its last value in IDLE.
REQ-024: A request arriving at cycle T SHALL produce its first strobe cycle at T+2 and done at T+2+StrobeWidth; throughput SHALL be one frame per 3+StrobeWidth cycles.
REQ-025: FrameStrobe SHALL never have more than one bit set, in any cycle.
REQ-026: cmd_valid, cmd_addr and cmd_data SHALL be ignored outside IDLE.

Reset
REQ-027: While reset=1, the block SHALL be in IDLE with cmd_ready=1, FrameData=0, FrameStrobe=0, done=0, addr_err=0 and frame_count=0.
REQ-028: Reset asserted mid-operation SHALL immediately and asynchronously clear FrameStrobe, abort the write without a done pulse, and leave frame_count unincremented.
REQ-029: addr_err SHALL be cleared only by reset.

Verification
REQ-030: StrobeWidth=2; request addr=5, data=0xDEADBEEF at T -> FrameData=0xDEADBEEF from T+1; FrameStrobe=0x00020 during T+2 and T+3; done at T+4; frame_count=1; cmd_ready high again at T+5.
REQ-031: Back-to-back requests for addr 0 then addr 19 with cmd_valid held high -> two strobe pulses, 0x00001 then 0x80000, separated by 5 cycles; no overlap; frame_count=2.
REQ-032: Request addr=20 -> addr_err=1; no strobe; FrameData unchanged; a following valid request completes normally with addr_err still 1.
REQ-033: Reset asserted during the first STROBE cycle -> FrameStrobe=0 in the same cycle; no done pulse; frame_count=0; IDLE after reset release.
REQ-034: Preload frame_count=0xFFFF by running 65535 writes (or by force), then one more write -> frame_count=0x0000.
REQ-035: Toggle cmd_valid and change cmd_addr/cmd_data during SETUP, STROBE and HOLD -> no effect on the in-flight strobe, FrameData or count.

Source files
------------

// File: rtl/frame_strobe_sequencer.sv
// Frame write sequencer: accepts one frame write, then walks SETUP -> STROBE -> HOLD
// to drive a one-hot, timed strobe toward the column tiles.
module frame_strobe_sequencer #(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned StrobeWidth     = 2
) (
  input  logic                       UserCLK,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [4:0]                 cmd_addr,
  input  logic [FrameBitsPerRow-1:0] cmd_data,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       done,
  output logic                       addr_err,
  output logic [15:0]                frame_count
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  localparam logic [3:0] CntLast = 4'(StrobeWidth - 1);

  state_e                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [4:0]                 addr_q, addr_d;
  logic [FrameBitsPerRow-1:0] data_q, data_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic                       ready_q, ready_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic [15:0]                count_q, count_d;
  logic                       addr_ok;

  assign addr_ok = 32'(cmd_addr) < MaxFramesPerCol;

  // Outputs are next-state decoded so every output is a flop; strobe is asserted
  // from the cycle the FSM enters STROBE and dropped on the edge into HOLD.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    strobe_d = '0;
    done_d   = 1'b0;
    err_d    = err_q;
    count_d  = count_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (addr_ok) begin
            addr_d  = cmd_addr;
            data_d  = cmd_data;
            state_d = SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d  = STROBE;
        cnt_d    = '0;
        strobe_d = MaxFramesPerCol'(1) << addr_q;
      end
      STROBE: begin
        if (cnt_q == CntLast) begin
          state_d = HOLD;
          done_d  = 1'b1;
          count_d = count_q + 16'd1;
        end else begin
          cnt_d    = cnt_q + 4'd1;
          strobe_d = MaxFramesPerCol'(1) << addr_q;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge UserCLK or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  assign cmd_ready   = ready_q;
  assign FrameData   = data_q;
  assign FrameStrobe = strobe_q;
  assign done        = done_q;
  assign addr_err    = err_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Scoreboard bench for frame_strobe_sequencer: stimulus pushes expected frames,
// a negedge monitor checks strobe/data/done/count timing against each frame.
module tb_frame_strobe_sequencer;
  localparam int NF = 20;
  localparam int FW = 32;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [4:0]    cmd_addr;
  logic [FW-1:0] cmd_data;
  logic [FW-1:0] FrameData;
  logic [NF-1:0] FrameStrobe;
  logic          done;
  logic          addr_err;
  logic [15:0]   frame_count;

  frame_strobe_sequencer #(
    .MaxFramesPerCol(NF),
    .FrameBitsPerRow(FW),
    .StrobeWidth    (SW)
  ) dut (
    .UserCLK    (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .FrameData  (FrameData),
    .FrameStrobe(FrameStrobe),
    .done       (done),
    .addr_err   (addr_err),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   addr;
    logic [FW-1:0] data;
    logic [15:0]   count;
    int            t_hs;
  } exp_t;

  exp_t          sb[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  int            busy = 0;
  logic          m_err = 1'b0;
  logic [15:0]   m_count = '0;
  logic [FW-1:0] last_data = '0;
  logic [15:0]   last_count = '0;
  bit            mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A frame occupies the sequencer for 3+SW cycles counted from the accepting edge.
  task automatic step(input logic v, input logic [4:0] a, input logic [FW-1:0] d);
    exp_t e;
    cmd_valid = v;
    cmd_addr  = a;
    cmd_data  = d;
    @(posedge clk);
    cyc++;
    if (busy == 0) begin
      if (v) begin
        if (int'(a) < NF) begin
          m_count++;
          e.addr  = a;
          e.data  = d;
          e.count = m_count;
          e.t_hs  = cyc;
          sb.push_back(e);
          busy = 2 + SW;
        end else begin
          m_err = 1'b1;
        end
      end
    end else begin
      busy--;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'($urandom_range(0, 31)), $urandom());
  endtask

  // Monitor: cycle offset from the accepting edge gives SETUP(0), STROBE(1..SW), HOLD(SW+1).
  initial begin : monitor
    int            rel;
    logic [NF-1:0] exp_strobe;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("cmd_ready", 64'(cmd_ready), 64'(busy == 0));
        chk("addr_err", 64'(addr_err), 64'(m_err));
        chk("strobe_onehot", 64'($countones(FrameStrobe) <= 1), 64'(1));
        if (sb.size() > 0) begin
          rel = cyc - sb[0].t_hs;
          exp_strobe = (rel >= 1 && rel <= SW) ? (NF'(1) << sb[0].addr) : '0;
          chk("strobe", 64'(FrameStrobe), 64'(exp_strobe));
          chk("done", 64'(done), 64'(rel == SW + 1));
          chk("frame_data", 64'(FrameData), 64'(sb[0].data));
          chk("frame_count", 64'(frame_count), 64'((rel == SW + 1) ? sb[0].count : last_count));
          if (rel >= SW + 1) begin
            if (rel > SW + 1) chk("done_timeout", 64'(0), 64'(1));
            last_data  = sb[0].data;
            last_count = sb[0].count;
            void'(sb.pop_front());
          end
        end else begin
          chk("idle_strobe", 64'(FrameStrobe), 64'(0));
          chk("idle_done", 64'(done), 64'(0));
          chk("idle_data", 64'(FrameData), 64'(last_data));
          chk("idle_count", 64'(frame_count), 64'(last_count));
        end
      end
    end
  end

  initial begin : stimulus
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    #2;
    chk("rst_ready", 64'(cmd_ready), 64'(1));
    chk("rst_data", 64'(FrameData), 64'(0));
    chk("rst_strobe", 64'(FrameStrobe), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(addr_err), 64'(0));
    chk("rst_count", 64'(frame_count), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    mon_en = 1'b1;

    step(1'b1, 5'd5, 32'hDEADBEEF);
    idle(6);

    step(1'b1, 5'd0, 32'h1111_0000);
    repeat (2 + SW + 1) step(1'b1, 5'd19, 32'h2222_0013);
    idle(6);

    step(1'b1, 5'd20, 32'h5555_5555);
    idle(2);
    step(1'b1, 5'd7, 32'h0707_0707);
    idle(6);

    repeat (400) step(1'($urandom_range(0, 9) < 7), 5'($urandom_range(0, 23)), $urandom());
    idle(8);

    // Counter wrap: jump the count to 0xFFFF while idle, then one more frame.
    #1 force dut.count_q = 16'hFFFF;
    #1 release dut.count_q;
    m_count    = 16'hFFFF;
    last_count = 16'hFFFF;
    idle(1);
    step(1'b1, 5'd3, 32'hCAFE_F00D);
    idle(6);
    chk("wrap_count", 64'(frame_count), 64'(0));

    step(1'b1, 5'd9, 32'h9999_0009);
    step(1'b0, 5'd0, 32'h0);
    chk("pre_reset_strobe", 64'(FrameStrobe), 64'(NF'(1) << 9));
    mon_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("async_rst_strobe", 64'(FrameStrobe), 64'(0));
    chk("async_rst_done", 64'(done), 64'(0));
    chk("async_rst_count", 64'(frame_count), 64'(0));
    chk("async_rst_ready", 64'(cmd_ready), 64'(1));
    @(posedge clk);
    #1;
    chk("rst_hold_done", 64'(done), 64'(0));
    #1 reset = 1'b0;
    sb.delete();
    busy       = 0;
    m_err      = 1'b0;
    m_count    = '0;
    last_data  = '0;
    last_count = '0;
    mon_en     = 1'b1;
    step(1'b1, 5'd4, 32'h4444_0004);
    idle(6);

    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
